down_counter_sync: RTL and testbench
====================================

# down_counter_sync

Synchronous down counter with parallel load, count enable and terminal-count borrow. It counts the other direction from the team's 4-bit ripple up-counter, from a loaded value down to zero. It sits beside that counter in the memory-circuits set and serves as a programmable interval/one-shot timer. Because it is fully synchronous, every output changes only on the rising edge of `count`.

## Interface

**Parameters**
- `WIDTH`, default 4: counter width; loadable range is 0 to 2^WIDTH-1.

**Ports**
- `count`, input, 1: clock; all state updates on the rising edge.
- `clear`, input, 1: reset, synchronous, active-low. It is sampled on the rising edge of `count` and has the highest priority.
- `load`, input, 1: when high, loads `din` into both the counter and the period register.
- `din`, input, WIDTH: load value.
- `en`, input, 1: count enable; one decrement per enabled cycle while running.
- `auto_reload`, input, 1: 1 selects periodic mode, 0 selects one-shot. Sampled on every edge.
- `out`, output, WIDTH: current count (registered).
- `zero`, output, 1: `out == 0`; a combinational decode of the `out` register.
- `borrow`, output, 1: registered one-cycle pulse on each terminal count.
- `busy`, output, 1: high while the FSM is in RUN (registered).

## Operation

**Reset** (`clear` = 0 at an edge):
- FSM goes to IDLE.
- `out` = 0, period = 0, `borrow` = 0, `busy` = 0, `zero` = 1.
- Overrides `load` and `en` in the same cycle.

**FSM states:** IDLE, RUN, DONE.
- IDLE: `en` is ignored; `load` exits.
- RUN: decrements on `en`.
- DONE: holds `out` = 0; `en` is ignored; only `load` exits.

**Load** (priority over `en`, legal in any state):
- `out` ← `din`, period ← `din`.
- If `din` != 0, next state is RUN. If `din` = 0, next state is DONE.
- `borrow` ← 0 in the load cycle.

**RUN with `en` = 1:**
- If `out` > 1: `out` ← `out` - 1, `borrow` ← 0.
- If `out` == 1 and `auto_reload` = 1: `out` ← period, `borrow` ← 1, stay in RUN.
- If `out` == 1 and `auto_reload` = 0: `out` ← 0, `borrow` ← 1, go to DONE.

**RUN with `en` = 0:** `out` holds, `borrow` ← 0.

**Periods:**
- Periodic mode with period N produces N, N-1, …, 1, N, …, with one `borrow` every N enabled cycles.
- Period 1 periodic: `out` stays 1 and `borrow` is high on every enabled cycle.

**Other rules:**
- `borrow` is 0 in IDLE and DONE except for the edge that enters DONE.
- Arithmetic is unsigned WIDTH-bit. `out` never wraps below 0: value 0 is never decremented.

## Timing

- Load latency: 1 edge. `out` = `din` and `busy` is valid in the cycle after the `load` edge.
- The first decrement happens at the first edge after the load edge with `en` = 1.
- `borrow` goes high in the same cycle that `out` shows the reload value or 0.
- `busy` falls in the same cycle `out` becomes 0 in one-shot mode.
- Toggling `auto_reload` mid-count only affects the next terminal-count decision.
- `load` coincident with a terminal count: the load wins, `borrow` = 0.
- `clear` coincident with `load` or a terminal count: reset wins.

## Test plan

- **Reset:** hold `clear` = 0 for 2 edges with `load` = 1, `din` = 9. Expect `out` = 0, `zero` = 1, `busy` = 0, `borrow` = 0.
- **One-shot:** load 5, `auto_reload` = 0, `en` = 1 continuously.
  - Expect `out` = 5, 4, 3, 2, 1, 0.
  - `borrow` high only in the cycle `out` first reads 0; `busy` drops in that cycle.
  - Further `en` leaves `out` = 0.
- **Periodic:** load 3, `auto_reload` = 1, `en` = 1.
  - Expect `out` = 3, 2, 1, 3, 2, 1, 3.
  - `borrow` high exactly in each cycle `out` returns to 3.
  - Period 1 gives `out` = 1 with `borrow` = 1 on every cycle.
- **Enable gating:** load 4, toggle `en` 1, 0, 0, 1. Expect `out` = 4, 3, 3, 3, 2 and no `borrow`.
- **Load mid-count and load 0:**
  - At `out` = 2, load 15: next `out` = 15 (max for WIDTH 4), `busy` = 1.
  - Load 0: `out` = 0, state DONE, `busy` = 0, `borrow` = 0.
  - Load 1 coincident with a terminal count: `out` = 1, `borrow` = 0.
- **Clear mid-run:** periodic period 6 running; drive `clear` = 0 at `out` = 4. Next cycle `out` = 0, `busy` = 0, and `en` is ignored until the next `load`.

Source files
------------

// File: rtl/down_counter_sync.sv
// down_counter_sync: loadable down counter with one-shot/periodic modes and terminal-count borrow.
module down_counter_sync #(
    parameter int WIDTH = 4
) (
    input  logic             count,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             borrow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d, period_q, period_d;
    logic             borrow_q, borrow_d, busy_q;
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        period_d = period_q;
        borrow_d = 1'b0;
        if (load) begin
            out_d    = din;
            period_d = din;
            state_d  = (din != '0) ? RUN : DONE;
        end else if (state_q == RUN && en) begin
            // Anything at or below 1 is a terminal count, so 0 is never decremented.
            borrow_d = (out_q <= WIDTH'(1));
            out_d    = (out_q > WIDTH'(1)) ? out_q - WIDTH'(1) : (auto_reload ? period_q : '0);
            state_d  = (out_q > WIDTH'(1) || auto_reload) ? RUN : DONE;
        end
    end
    always_ff @(posedge count) begin
        if (!clear) begin
            state_q  <= IDLE;
            out_q    <= '0;
            period_q <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            period_q <= period_d;
            borrow_q <= borrow_d;
            busy_q   <= (state_d == RUN);
        end
    end
    assign out    = out_q;
    assign zero   = (out_q == '0);
    assign borrow = borrow_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_down_counter_sync.sv
// tb_down_counter_sync: directed-vector bench with immediate assertions for down_counter_sync.
module tb_down_counter_sync;
    logic       clk = 1'b0;
    logic       clear, load, en, auto_reload;
    logic [3:0] din;
    logic [3:0] out;
    logic       zero, borrow, busy;
    int         n_chk = 0;
    int         n_fail = 0;

    down_counter_sync #(.WIDTH(4)) dut (
        .count(clk), .clear(clear), .load(load), .din(din), .en(en),
        .auto_reload(auto_reload), .out(out), .zero(zero), .borrow(borrow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks every output; zero is expected to track the expected count.
    task automatic expect_all(input string tag, input int o, input bit b, input bit bz);
        chk({tag, ".out"}, 32'(out), 32'(o));
        chk({tag, ".borrow"}, 32'(borrow), 32'(b));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
        chk({tag, ".zero"}, 32'(zero), 32'(o == 0));
    endtask

    initial begin
        clear = 1'b0; load = 1'b1; din = 4'd9; en = 1'b1; auto_reload = 1'b0;
        tick; tick;
        expect_all("reset", 0, 0, 0);

        clear = 1'b1; load = 1'b1; din = 4'd5;
        tick; expect_all("os_load", 5, 0, 1);
        load = 1'b0;
        tick; expect_all("os_4", 4, 0, 1);
        tick; expect_all("os_3", 3, 0, 1);
        tick; expect_all("os_2", 2, 0, 1);
        tick; expect_all("os_1", 1, 0, 1);
        tick; expect_all("os_0", 0, 1, 0);
        tick; expect_all("os_hold", 0, 0, 0);
        tick; expect_all("os_hold2", 0, 0, 0);

        load = 1'b1; din = 4'd3; auto_reload = 1'b1;
        tick; expect_all("per_load", 3, 0, 1);
        load = 1'b0;
        tick; expect_all("per_2a", 2, 0, 1);
        tick; expect_all("per_1a", 1, 0, 1);
        tick; expect_all("per_3a", 3, 1, 1);
        tick; expect_all("per_2b", 2, 0, 1);
        tick; expect_all("per_1b", 1, 0, 1);
        tick; expect_all("per_3b", 3, 1, 1);

        load = 1'b1; din = 4'd1;
        tick; expect_all("p1_load", 1, 0, 1);
        load = 1'b0;
        tick; expect_all("p1_a", 1, 1, 1);
        tick; expect_all("p1_b", 1, 1, 1);
        tick; expect_all("p1_c", 1, 1, 1);

        load = 1'b1; din = 4'd4; auto_reload = 1'b0; en = 1'b0;
        tick; expect_all("en_load", 4, 0, 1);
        load = 1'b0; en = 1'b1;
        tick; expect_all("en_1", 3, 0, 1);
        en = 1'b0;
        tick; expect_all("en_0a", 3, 0, 1);
        tick; expect_all("en_0b", 3, 0, 1);
        en = 1'b1;
        tick; expect_all("en_1b", 2, 0, 1);

        load = 1'b1; din = 4'd15;
        tick; expect_all("ld_max", 15, 0, 1);
        din = 4'd0;
        tick; expect_all("ld_zero", 0, 0, 0);
        load = 1'b0;
        tick; expect_all("done_ign_en", 0, 0, 0);

        load = 1'b1; din = 4'd2;
        tick; expect_all("tc_load2", 2, 0, 1);
        load = 1'b0;
        tick; expect_all("tc_1", 1, 0, 1);
        load = 1'b1; din = 4'd1;
        tick; expect_all("tc_vs_load", 1, 0, 1);

        din = 4'd6; auto_reload = 1'b1;
        tick; expect_all("clr_load6", 6, 0, 1);
        load = 1'b0;
        tick; expect_all("clr_5", 5, 0, 1);
        tick; expect_all("clr_4", 4, 0, 1);
        clear = 1'b0;
        tick; expect_all("clr_hit", 0, 0, 0);
        clear = 1'b1;
        tick; expect_all("clr_idle_a", 0, 0, 0);
        tick; expect_all("clr_idle_b", 0, 0, 0);

        load = 1'b1; din = 4'd1; en = 1'b1; clear = 1'b0;
        tick; expect_all("clr_vs_load", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
